systolic_ws_ctrl: RTL
=====================

SYSTOLIC_WS_CTRL -- requirements
Module: systolic_ws_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the element width in bits.
REQ-002 The block SHALL have parameter ROW_NUM, default 8, giving the weight-matrix row count, which is also the west-input count.
REQ-003 The block SHALL have parameter COL_NUM, default 8, giving the weight-matrix column count, which is also the north/south count.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the vector-count field.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have ports start (input, 1 bit) and vec_count (input, CNT_W bits): a job request carrying the number of activation vectors.
REQ-008 The block SHALL have ports busy (output, 1 bit) and done (output, 1 bit, single-cycle pulse) for job status.
REQ-009 The block SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, COL_NUM*DATA_WIDTH) for one weight row per handshake; column j is at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-010 The block SHALL have ports a_valid (input, 1), a_ready (output, 1) and a_data (input, ROW_NUM*DATA_WIDTH) for one activation vector per handshake; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL have ports weights (output, ROW_NUM*COL_NUM*DATA_WIDTH, row-major), norths (output, COL_NUM*DATA_WIDTH), wests (output, ROW_NUM*DATA_WIDTH) and souths (input, COL_NUM*DATA_WIDTH) to drive and observe the PE array.
REQ-012 The block SHALL have ports o_valid (output, 1) and o_data (output, COL_NUM*DATA_WIDTH) carrying the aligned result vector; there is no backpressure on the result.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, STREAM, DRAIN and DONE; busy SHALL be 1 in every state except IDLE.
REQ-014 In IDLE, start=1 SHALL latch vec_count, clear the row and vector counters, and go to LOAD; start in any other state SHALL be ignored.
REQ-015 In LOAD, w_ready SHALL be 1; handshake k (k = 0..ROW_NUM-1) SHALL write weight row k; after handshake ROW_NUM-1 the FSM SHALL go to STREAM, or to DONE if the latched count is 0.
REQ-016 In STREAM, a_ready SHALL be 1 until the latched count of vectors has been accepted; on the last acceptance the FSM SHALL go to DRAIN; a_ready SHALL be 0 in all other states.
REQ-017 Skew: element i of a vector accepted at edge t SHALL appear on wests[i] in cycle t+1+i (i+1 register stages); a cycle with no acceptance SHALL inject zero into the skew lines.
REQ-018 norths SHALL be constant zero.
REQ-019 Deskew: souths[j] SHALL be delayed by COL_NUM-1-j register stages so that all columns of one vector align.
REQ-020 o_valid SHALL be 1 in exactly cycle t+ROW_NUM+COL_NUM for each vector accepted at edge t (fixed latency L = ROW_NUM+COL_NUM), tracked by an L-deep valid shift register.
REQ-021 o_data[j] SHALL equal the sum over i of a[i]*W[i][j], modulo 2^DATA_WIDTH, matching the array arithmetic.
REQ-022 DRAIN SHALL exit to DONE in the cycle after the valid shift register becomes empty.
REQ-023 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-024 The weights output SHALL stay stable from the end of LOAD until the next LOAD.
REQ-025 Back-to-back vectors (a_valid held at 1) SHALL be accepted one per cycle, and results SHALL emerge on consecutive cycles.

Reset
REQ-026 While reset=0: FSM in IDLE; busy, done, w_ready, a_ready and o_valid at 0; all skew, deskew, valid and weight registers at 0; counters at 0.
REQ-027 Assertion of reset mid-job SHALL abort the job immediately; no done and no further o_valid SHALL follow.

Configuration
REQ-028 With SYSTOLIC_WS_CTRL_PERF_EN defined, the block SHALL add an output perf_cycles (32 bits) that counts busy cycles of the current job, clears on start acceptance, holds after DONE, and resets to 0.
REQ-029 Without SYSTOLIC_WS_CTRL_PERF_EN, the perf_cycles port and its counter SHALL be absent.

Verification
REQ-030 With ROW_NUM=COL_NUM=2, W=[[1,2],[3,4]], one vector a=[5,6] accepted at edge t -> o_valid only at cycle t+4, with o_data=[23,34].
REQ-031 Same W, vectors [1,0], [0,1], [2,2] accepted back-to-back -> results [1,2], [3,4], [8,12] on three consecutive cycles; done fires after the third result, and busy then falls.
REQ-032 start with vec_count=0 -> two weight rows accepted, then done pulses with no o_valid and a_ready never 1.
REQ-033 Gaps in a_valid (1,0,0,1) -> results spaced identically, with no spurious o_valid in the gaps.
REQ-034 DATA_WIDTH=8, W all 16, a all 16 -> o_data = 0 (wrap mod 256); start pulsed during STREAM -> ignored.
REQ-035 reset pulsed low in the middle of STREAM -> all outputs 0 immediately, with no done; a new job then completes correctly.

Source files
------------

// File: rtl/systolic_ws_ctrl.sv
// systolic_ws_ctrl: controller for a weight-stationary systolic PE array.
// Loads ROW_NUM weight rows, streams activation vectors into the west edge
// through a triangular skew, deskews the south edge and emits aligned
// result vectors with fixed latency ROW_NUM+COL_NUM.
// Optional build macro SYSTOLIC_WS_CTRL_PERF_EN adds a 32-bit busy-cycle
// counter output (perf_cycles).

// Fixed-depth register delay line for one DATA_WIDTH lane (DEPTH >= 1).
module ws_delay_line #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);
    logic [DEPTH-1:0][DW-1:0] r_pipe;

    // shift the lane one stage per clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

module systolic_ws_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 8,
    parameter int COL_NUM    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [CNT_W-1:0]                      vec_count,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  w_valid,
    output logic                                  w_ready,
    input  logic [COL_NUM*DATA_WIDTH-1:0]         w_data,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [ROW_NUM*DATA_WIDTH-1:0]         a_data,
    output logic [ROW_NUM*COL_NUM*DATA_WIDTH-1:0] weights,
    output logic [COL_NUM*DATA_WIDTH-1:0]         norths,
    output logic [ROW_NUM*DATA_WIDTH-1:0]         wests,
    input  logic [COL_NUM*DATA_WIDTH-1:0]         souths,
    output logic                                  o_valid,
    output logic [COL_NUM*DATA_WIDTH-1:0]         o_data
`ifdef SYSTOLIC_WS_CTRL_PERF_EN
    ,
    output logic [31:0]                           perf_cycles
`endif
);
    localparam int L  = ROW_NUM + COL_NUM;
    localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                                  r_state;
    logic                                    r_busy;
    logic                                    r_done;
    logic                                    r_w_ready;
    logic                                    r_a_ready;
    logic [RW-1:0]                           r_row;
    logic [CNT_W-1:0]                        r_count;
    logic [CNT_W-1:0]                        r_vec;
    logic [ROW_NUM-1:0][COL_NUM*DATA_WIDTH-1:0] r_weights;
    logic [L-1:0]                            r_vld;

    logic                                    w_wt_hs;
    logic                                    w_act_hs;
    logic [ROW_NUM-1:0][DATA_WIDTH-1:0]      w_skew_in;
    logic [COL_NUM-1:0][DATA_WIDTH-1:0]      w_desk;

    assign w_wt_hs  = w_valid & r_w_ready;
    assign w_act_hs = a_valid & r_a_ready;

    // job sequencer: all status/handshake outputs are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w_ready <= 1'b0;
            r_a_ready <= 1'b0;
            r_row     <= '0;
            r_count   <= '0;
            r_vec     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= vec_count;
                        r_row     <= '0;
                        r_vec     <= '0;
                        r_busy    <= 1'b1;
                        r_w_ready <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_wt_hs) begin
                        r_row <= r_row + 1'b1;
                        if (r_row == RW'(ROW_NUM - 1)) begin
                            r_w_ready <= 1'b0;
                            if (r_count == '0) begin
                                // empty job: skip streaming entirely
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_a_ready <= 1'b1;
                                r_state   <= S_STREAM;
                            end
                        end
                    end
                end
                S_STREAM: begin
                    if (w_act_hs) begin
                        r_vec <= r_vec + 1'b1;
                        if (r_vec == r_count - CNT_W'(1)) begin
                            r_a_ready <= 1'b0;
                            r_state   <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // wait until every in-flight vector has been emitted
                    if (r_vld == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign w_ready = r_w_ready;
    assign a_ready = r_a_ready;

    // weight rows are captured only during LOAD, so they hold until the next job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_weights <= '0;
        end else if (w_wt_hs) begin
            r_weights[r_row] <= w_data;
        end
    end

    assign weights = r_weights;
    assign norths  = '0;

    // track each accepted vector through the fixed array latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[L-2:0], w_act_hs};
        end
    end

    // idle cycles inject zeros so stale data never enters the array
    always_comb begin
        w_skew_in = '0;
        for (int i = 0; i < ROW_NUM; i++) begin
            if (w_act_hs) begin
                w_skew_in[i] = a_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // west skew: row i is delayed i+1 stages
    for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_skew
        ws_delay_line #(
            .DW   (DATA_WIDTH),
            .DEPTH(gi + 1)
        ) u_skew (
            .i_clk  (clk),
            .i_rst_n(reset),
            .i_d    (w_skew_in[gi]),
            .o_q    (wests[gi*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // south deskew: column j is delayed COL_NUM-1-j stages; the last column is direct
    for (genvar gj = 0; gj < COL_NUM; gj++) begin : g_desk
        if (COL_NUM - 1 - gj > 0) begin : g_dly
            ws_delay_line #(
                .DW   (DATA_WIDTH),
                .DEPTH(COL_NUM - 1 - gj)
            ) u_desk (
                .i_clk  (clk),
                .i_rst_n(reset),
                .i_d    (souths[gj*DATA_WIDTH +: DATA_WIDTH]),
                .o_q    (w_desk[gj])
            );
        end else begin : g_pass
            assign w_desk[gj] = souths[gj*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // result is forced to zero outside its valid cycle so aborts leave no residue
    assign o_valid = r_vld[L-1];
    assign o_data  = r_vld[L-1] ? w_desk : '0;

`ifdef SYSTOLIC_WS_CTRL_PERF_EN
    logic [31:0] r_perf;

    // count busy cycles of the current job; cleared when a job is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_perf <= '0;
        end else if (r_busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`else
    // no busy-cycle counter in this build
`endif
endmodule
